// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder: turns symbolic op requests into machine words and
// streams them into instruction memory over a backpressured write port.
module rv32_instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BLTU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  } op_e;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

  state_e            state, state_n;
  fmt_e              fmt;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       enc_word;
  logic              op_valid;
  logic              in_ready_n, mem_we_n, full_n, err_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic [ADDR_W:0]   count_n, count_inc;

  assign op_valid = (in_op <= 5'd28);

  // Per-op format, opcode and function fields.
  always_comb begin
    fmt = FMT_NONE;
    opc = 7'b0000000;
    f3  = 3'b000;
    f7  = 7'b0000000;
    case (op_e'(in_op))
      OP_ADD:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b000; end
      OP_SUB:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      OP_SLL:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b001; end
      OP_SLT:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b010; end
      OP_SLTU:  begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b011; end
      OP_XOR:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b100; end
      OP_SRL:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b101; end
      OP_SRA:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b101; f7 = 7'b0100000; end
      OP_OR:    begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b110; end
      OP_AND:   begin fmt = FMT_R;  opc = 7'b0110011; f3 = 3'b111; end
      OP_ADDI:  begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b000; end
      OP_SLTI:  begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b010; end
      OP_SLTIU: begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b011; end
      OP_XORI:  begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b100; end
      OP_ORI:   begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b110; end
      OP_ANDI:  begin fmt = FMT_I;  opc = 7'b0010011; f3 = 3'b111; end
      OP_SLLI:  begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b001; end
      OP_SRLI:  begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b101; end
      OP_SRAI:  begin fmt = FMT_SH; opc = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; end
      OP_LW:    begin fmt = FMT_I;  opc = 7'b0000011; f3 = 3'b010; end
      OP_SW:    begin fmt = FMT_S;  opc = 7'b0100011; f3 = 3'b010; end
      OP_BEQ:   begin fmt = FMT_B;  opc = 7'b1100011; f3 = 3'b000; end
      OP_BNE:   begin fmt = FMT_B;  opc = 7'b1100011; f3 = 3'b001; end
      OP_BLT:   begin fmt = FMT_B;  opc = 7'b1100011; f3 = 3'b100; end
      OP_BLTU:  begin fmt = FMT_B;  opc = 7'b1100011; f3 = 3'b110; end
      OP_JAL:   begin fmt = FMT_J;  opc = 7'b1101111; end
      OP_JALR:  begin fmt = FMT_I;  opc = 7'b1100111; f3 = 3'b000; end
      OP_LUI:   begin fmt = FMT_U;  opc = 7'b0110111; end
      OP_AUIPC: begin fmt = FMT_U;  opc = 7'b0010111; end
      default:  fmt = FMT_NONE;
    endcase
  end

  // Field packing; registers a format does not use are simply left out.
  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      FMT_R:   enc_word = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      FMT_I:   enc_word = {in_imm[11:0], in_rs1, f3, in_rd, opc};
      FMT_SH:  enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
      FMT_S:   enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
      FMT_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                           in_imm[4:1], in_imm[11], opc};
      FMT_U:   enc_word = {in_imm[31:12], in_rd, opc};
      FMT_J:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
      default: enc_word = 32'h0;
    endcase
  end

  // Next-state and next-output logic; clear overrides any handshake or write.
  always_comb begin
    state_n     = state;
    in_ready_n  = in_ready;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    count_n     = word_count;
    full_n      = full;
    err_n       = err;
    count_inc   = word_count + CW'(1);
    if (clear) begin
      state_n    = IDLE;
      in_ready_n = 1'b1;
      mem_we_n   = 1'b0;
      mem_addr_n = '0;
      count_n    = '0;
      full_n     = 1'b0;
      err_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_n = 1'b1;
          if (in_valid && in_ready) begin
            if (op_valid) begin
              state_n     = WRITE;
              in_ready_n  = 1'b0;
              mem_we_n    = 1'b1;
              mem_wdata_n = enc_word;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we_n   = 1'b0;
            count_n    = count_inc;
            mem_addr_n = count_inc[ADDR_W-1:0];
            if (count_inc == CW'(MAX_WORDS)) begin
              state_n = FULL;
              full_n  = 1'b1;
            end else begin
              state_n    = IDLE;
              in_ready_n = 1'b1;
            end
          end
        end
        FULL: begin
          in_ready_n = 1'b0;
          mem_we_n   = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready   <= in_ready_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      word_count <= count_n;
      full       <= full_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed bench for rv32_instr_encoder: encoding table plus handshake,
// backpressure, invalid-op, full, clear and reset sequences.
module tb_rv32_instr_encoder;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 4;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[14];

  rv32_instr_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{5'd0,  5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h0020_81B3};
    vecs[1]  = '{5'd1,  5'd5,  5'd6,  5'd7,  32'h0000_0000, 32'h4073_02B3};
    vecs[2]  = '{5'd10, 5'd1,  5'd0,  5'd4,  32'h0000_0005, 32'h0050_0093};
    vecs[3]  = '{5'd20, 5'd9,  5'd1,  5'd2,  32'h0000_000C, 32'h0020_A623};
    vecs[4]  = '{5'd21, 5'd0,  5'd1,  5'd2,  32'h0000_0009, 32'h0020_8463};
    vecs[5]  = '{5'd25, 5'd1,  5'd3,  5'd4,  32'h0000_0010, 32'h0100_00EF};
    vecs[6]  = '{5'd27, 5'd10, 5'd7,  5'd0,  32'h1234_5000, 32'h1234_5537};
    vecs[7]  = '{5'd18, 5'd4,  5'd4,  5'd0,  32'h0000_0003, 32'h4032_5213};
    vecs[8]  = '{5'd28, 5'd5,  5'd0,  5'd0,  32'hFFFF_F123, 32'hFFFF_F297};
    vecs[9]  = '{5'd19, 5'd2,  5'd3,  5'd9,  32'hFFFF_FFFC, 32'hFFC1_A103};
    vecs[10] = '{5'd24, 5'd7,  5'd5,  5'd6,  32'hFFFF_FFFE, 32'hFE62_EFE3};
    vecs[11] = '{5'd26, 5'd1,  5'd2,  5'd0,  32'h0000_0123, 32'h1231_00E7};
    vecs[12] = '{5'd4,  5'd31, 5'd30, 5'd29, 32'h0000_0000, 32'h01DF_3FB3};
    vecs[13] = '{5'd16, 5'd1,  5'd1,  5'd0,  32'hFFFF_FFE5, 32'h0050_9093};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Encoding table; clear every three words so the small depth never fills.
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (cnt == 3) begin
        chk($sformatf("vec%0d_count3", i), 32'(word_count), 32'd3);
        do_clear();
        cnt = 0;
      end
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(cnt));
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].word);
      @(negedge clk);
      chk($sformatf("vec%0d_we_drop", i), 32'(mem_we), 32'd0);
      chk($sformatf("vec%0d_count", i), 32'(word_count), 32'(cnt + 1));
      cnt++;
    end

    // Backpressure: write held stable while mem_ready is low.
    do_clear();
    mem_ready = 1'b0;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_we", 32'(mem_we), 32'd1);
      chk("bp_addr", 32'(mem_addr), 32'd0);
      chk("bp_wdata", mem_wdata, 32'h0020_81B3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_count", 32'(word_count), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_count", 32'(word_count), 32'd1);
    chk("bp_done_we", 32'(mem_we), 32'd0);
    chk("bp_done_in_ready", 32'(in_ready), 32'd1);

    // Invalid op: consumed, sticky err, no write.
    send(5'd30, 5'd1, 5'd1, 5'd1, 32'h0);
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_we", 32'(mem_we), 32'd0);
    chk("inv_count", 32'(word_count), 32'd1);
    chk("inv_in_ready", 32'(in_ready), 32'd1);
    send(5'd10, 5'd1, 5'd0, 5'd0, 32'h5);
    chk("inv_next_we", 32'(mem_we), 32'd1);
    chk("inv_next_addr", 32'(mem_addr), 32'd1);
    chk("inv_next_wdata", mem_wdata, 32'h0050_0093);
    @(negedge clk);
    chk("inv_next_count", 32'(word_count), 32'd2);
    chk("inv_err_sticky", 32'(err), 32'd1);

    // Fill to MAX_WORDS, then confirm requests are blocked.
    do_clear();
    chk("clr_err", 32'(err), 32'd0);
    send(5'd29, 5'd0, 5'd0, 5'd0, 32'h0);
    chk("fill_err", 32'(err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      send(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);
      @(negedge clk);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(word_count), 32'd4);
    in_op = 5'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_block_ready", 32'(in_ready), 32'd0);
      chk("full_block_we", 32'(mem_we), 32'd0);
      chk("full_block_count", 32'(word_count), 32'd4);
    end
    in_valid = 1'b0;
    do_clear();
    chk("unfull_count", 32'(word_count), 32'd0);
    chk("unfull_full", 32'(full), 32'd0);
    chk("unfull_err", 32'(err), 32'd0);
    chk("unfull_in_ready", 32'(in_ready), 32'd1);
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'h0);
    chk("unfull_addr", 32'(mem_addr), 32'd0);
    chk("unfull_wdata", mem_wdata, 32'h4073_02B3);
    @(negedge clk);
    chk("unfull_count1", 32'(word_count), 32'd1);

    // clear in the same cycle as mem_ready drops the write.
    mem_ready = 1'b0;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    chk("clrw_we", 32'(mem_we), 32'd1);
    chk("clrw_addr", 32'(mem_addr), 32'd1);
    mem_ready = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clrw_count", 32'(word_count), 32'd0);
    chk("clrw_we_drop", 32'(mem_we), 32'd0);
    chk("clrw_in_ready", 32'(in_ready), 32'd1);
    chk("clrw_addr0", 32'(mem_addr), 32'd0);

    // rst during a pending write zeroes every output.
    send(5'd31, 5'd0, 5'd0, 5'd0, 32'h0);
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'h0);
    chk("rstw_we", 32'(mem_we), 32'd1);
    chk("rstw_count", 32'(word_count), 32'd1);
    chk("rstw_err", 32'(err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_in_ready0", 32'(in_ready), 32'd0);
    chk("rstw_we0", 32'(mem_we), 32'd0);
    chk("rstw_addr0", 32'(mem_addr), 32'd0);
    chk("rstw_wdata0", mem_wdata, 32'd0);
    chk("rstw_count0", 32'(word_count), 32'd0);
    chk("rstw_full0", 32'(full), 32'd0);
    chk("rstw_err0", 32'(err), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rstw_in_ready1", 32'(in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
